ram_fifo_ctrl: RTL
==================

# ram_fifo_ctrl

FIFO controller that sits directly upstream of the team's single-port RAM. It turns a push/pop handshake interface into the RAM's `cs`/`wr_en`/`rd_en`/address/data strobes, and returns read data one cycle after each accepted pop. Because the RAM has one port, the controller issues at most one access per cycle. It arbitrates between simultaneous push and pop requests by strict alternation.

## Interface
- `data_size`, default 8: width of stored words.
- `address_size`, default 4: RAM address width. Depth `DEPTH = 2**address_size`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `push_valid`  in  1  producer has a word on `push_data`.
- `push_data`  in  data_size  word to store.
- `push_ready`  out  1  push accepted this cycle when `push_valid && push_ready`.
- `pop_req`  in  1  consumer requests one word.
- `pop_ack`  out  1  pop accepted this cycle.
- `rdata`  out  data_size  popped word; passthrough of `ram_data_out`.
- `rdata_valid`  out  1  `rdata` holds the word for the pop acked in the previous cycle.
- `ram_cs`, `ram_wr_en`, `ram_rd_en`  out  1 each  RAM strobes.
- `ram_address`  out  address_size  RAM address.
- `ram_data_in`  out  data_size  RAM write data.
- `ram_data_out`  in  data_size  RAM registered read data.
- `count`  out  address_size+1  words stored, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.

## Operation
- State: `wr_ptr`, `rd_ptr` (address_size bits each), `count`, `last_grant` (1 = last arbitrated grant was a read), `rdata_valid` register.
- Eligibility:
  - `w_elig = push_valid && !full`.
  - `r_elig = pop_req && !empty`.
- Grant, combinational, evaluated each cycle:
  - Only `w_elig` → write.
  - Only `r_elig` → read.
  - Both → the type not granted last. If `last_grant == 1`, grant the write; otherwise grant the read.
  - Neither → idle.
- `last_grant` updates only on cycles where both were eligible.
- Outputs:
  - `push_ready = !full && !(r_elig && last_grant == 0)`.
  - `pop_ack = read granted`.
  - `push_ready` may depend combinationally on `pop_req`. `pop_ack` may depend combinationally on `push_valid`.
- Write grant:
  - `ram_cs=1`, `ram_wr_en=1`, `ram_rd_en=0`, `ram_address=wr_ptr`, `ram_data_in=push_data`.
  - `wr_ptr` increments at the edge.
- Read grant:
  - `ram_cs=1`, `ram_rd_en=1`, `ram_wr_en=0`, `ram_address=rd_ptr`.
  - `rd_ptr` increments at the edge.
  - `rdata_valid` is 1 in the next cycle.
- Idle:
  - `ram_cs`, `ram_wr_en`, `ram_rd_en` all 0.
  - `ram_address`, `ram_data_in` are don't-care; drive `wr_ptr` and `push_data`.
- `ram_wr_en` and `ram_rd_en` are never both 1.
- `count` changes by +1 on a write grant and −1 on a read grant. Both cannot occur in one cycle.
- Pointers wrap from `DEPTH-1` to 0 by natural overflow. No extra wrap logic.
- Boundary cases:
  - Push while full: `push_ready=0`; `push_data` must be held by the producer.
  - Pop while empty: `pop_ack=0`. No RAM read is issued and `rdata_valid` stays 0.
  - Empty FIFO with push and pop in the same cycle: `r_elig=0`, so the write is granted. The pop can be acked the next cycle.
  - Full FIFO with push and pop in the same cycle: `w_elig=0`, so the read is granted.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `wr_ptr`, `rd_ptr`, `count` = 0; `last_grant` = 1, so the first contested cycle grants the write; `rdata_valid` = 0.
  - While reset is low, `ram_cs`, `ram_wr_en`, `ram_rd_en`, `push_ready`, `pop_ack` are all forced to 0.
  - `empty=1`, `full=0`.
- Read latency:
  - `pop_ack` in cycle N → RAM samples at the edge ending N.
  - `rdata` and `rdata_valid` are valid throughout cycle N+1.
  - `rdata` is undefined (the RAM may drive Z) when `rdata_valid=0`.
- Write latency: data is committed at the edge ending the grant cycle. A read of the same address in the next cycle returns the new data.
- Throughput:
  - One access per cycle.
  - Sustained simultaneous push/pop alternates W,R,W,R…, giving 0.5 words/cycle each way.
- Reset mid-operation:
  - All state clears immediately.
  - A pop acked in the cycle before reset asserted does not produce `rdata_valid`.
  - Stored RAM contents are abandoned; the FIFO is empty after reset.

## Test plan
- Reset check:
  - Stimulus: assert `reset_n`=0 for 3 cycles with `push_valid=1` and `pop_req=1`.
  - Required: `ram_cs=0`, `push_ready=0`, `pop_ack=0`, `count=0`, `empty=1`, `full=0`, `rdata_valid=0`.
- Fill:
  - Stimulus: push 0xA1..0xB0 on 16 consecutive cycles, then hold 0xB1.
  - Required: `ram_address` 0..15; `full=1` and `count=16` after the 16th push; `push_ready=0`; 0xB1 not written.
- Drain:
  - Stimulus: from full, hold `pop_req=1` for 17 cycles.
  - Required: `rdata` 0xA1..0xB0 in order, each with `rdata_valid` one cycle after its `pop_ack`; `empty=1` after the 16th pop; no 17th ack.
- Contention:
  - Stimulus: with `count=4`, hold `push_valid=1` and `pop_req=1` for 8 cycles.
  - Required: grants W,R,W,R,W,R,W,R; `count` follows 5,4,5,4,…; `ram_wr_en && ram_rd_en` never both 1.
- Wrap-around:
  - Stimulus: push 12 words, pop 12, then push 0x10..0x17.
  - Required: write addresses 12,13,14,15,0,1,2,3; popping 8 returns 0x10..0x17 in order.
- Mid-op reset:
  - Stimulus: with `count=3`, ack a pop in cycle N, assert `reset_n`=0 in cycle N+1.
  - Required: `rdata_valid` stays 0; `count=0`; a push after release writes address 0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM: converts push/pop handshakes into
// RAM strobes, alternating between contending pushes and pops, one access per cycle.
module ram_fifo_ctrl #(
    parameter int unsigned data_size    = 8,
    parameter int unsigned address_size = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push_valid,
    input  logic [data_size-1:0]    push_data,
    output logic                    push_ready,
    input  logic                    pop_req,
    output logic                    pop_ack,
    output logic [data_size-1:0]    rdata,
    output logic                    rdata_valid,
    output logic                    ram_cs,
    output logic                    ram_wr_en,
    output logic                    ram_rd_en,
    output logic [address_size-1:0] ram_address,
    output logic [data_size-1:0]    ram_data_in,
    input  logic [data_size-1:0]    ram_data_out,
    output logic [address_size:0]   count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned DEPTH = 2 ** address_size;
    localparam int unsigned CW    = address_size + 1;

    logic [address_size-1:0] wr_ptr;
    logic [address_size-1:0] rd_ptr;
    logic                    last_grant;
    logic                    w_elig;
    logic                    r_elig;
    logic                    grant_wr;
    logic                    grant_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == CW'(0));
    assign rdata = ram_data_out;

    // Arbitration and RAM strobes; everything is held off while reset is asserted.
    always_comb begin
        w_elig      = push_valid && !full;
        r_elig      = pop_req && !empty;
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;
        if (reset_n) begin
            if (w_elig && r_elig) begin
                grant_wr = last_grant;
                grant_rd = !last_grant;
            end else begin
                grant_wr = w_elig;
                grant_rd = r_elig;
            end
        end
        push_ready  = reset_n && !full && !(r_elig && !last_grant);
        pop_ack     = grant_rd;
        ram_cs      = grant_wr || grant_rd;
        ram_wr_en   = grant_wr;
        ram_rd_en   = grant_rd;
        ram_address = grant_rd ? rd_ptr : wr_ptr;
        ram_data_in = push_data;
    end

    // Pointers, occupancy and alternation history; pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            last_grant  <= 1'b1;
            rdata_valid <= 1'b0;
        end else begin
            if (grant_wr) begin
                wr_ptr <= wr_ptr + address_size'(1);
                count  <= count + CW'(1);
            end
            if (grant_rd) begin
                rd_ptr <= rd_ptr + address_size'(1);
                count  <= count - CW'(1);
            end
            if (w_elig && r_elig) begin
                last_grant <= grant_rd;
            end
            rdata_valid <= grant_rd;
        end
    end

endmodule
